vga_fb_core: RTL and testbench

Parametrised single-clock VGA scan-out core: programmable-timing raster counters, on-chip indexed framebuffer with integer pixel scaling, programmable 12-bit RGB palette, and a write port that is granted only while the scan-out is not reading. It sits between the pixel-clock domain's drawing logic and the VGA connector pins, replacing fixed 2-bit colour decoding with a configurable palette and blanking-time framebuffer writes.

---
 rtl/vga_fb_core.sv | 207 ++++++++++++++++++++
 tb/tb_vga_fb_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_core.sv
`timescale 1ns/1ps
// vga_fb_core
//   Single-clock VGA scan-out: programmable raster counters, indexed on-chip
//   framebuffer with 2**SCALE_LOG2 pixel replication, 12-bit RGB444 palette,
//   and a framebuffer write port granted whenever scan-out is not reading.
// Ports
//   clk_i, arst_i          pixel clock, async active-high reset
//   en_i                   scan-out enable (low: counters parked at (0,0))
//   hd/hf/hr/hb_i          h display / front porch / sync / back porch
//   vd/vf/vr/vb_i          v display / front porch / sync / back porch
//   wr_req_i, wr_x_i, wr_y_i, wr_idx_i, wr_gnt_o, wr_err_o  framebuffer write
//   pal_we_i, pal_addr_i, pal_data_i                       palette write
//   vga_hs_o, vga_vs_o, rgb_o, frame_start_o               video out (2-cycle latency)
module vga_fb_core #(
    parameter int   H_MAX_W    = 11,
    parameter int   V_MAX_W    = 11,
    parameter int   FB_W       = 320,
    parameter int   FB_H       = 240,
    parameter int   IDX_W      = 2,
    parameter int   SCALE_LOG2 = 1,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      en_i,
    input  logic [H_MAX_W-1:0]        hd_i,
    input  logic [H_MAX_W-1:0]        hf_i,
    input  logic [H_MAX_W-1:0]        hr_i,
    input  logic [H_MAX_W-1:0]        hb_i,
    input  logic [V_MAX_W-1:0]        vd_i,
    input  logic [V_MAX_W-1:0]        vf_i,
    input  logic [V_MAX_W-1:0]        vr_i,
    input  logic [V_MAX_W-1:0]        vb_i,
    input  logic                      wr_req_i,
    input  logic [$clog2(FB_W)-1:0]   wr_x_i,
    input  logic [$clog2(FB_H)-1:0]   wr_y_i,
    input  logic [IDX_W-1:0]          wr_idx_i,
    output logic                      wr_gnt_o,
    output logic                      wr_err_o,
    input  logic                      pal_we_i,
    input  logic [IDX_W-1:0]          pal_addr_i,
    input  logic [11:0]               pal_data_i,
    output logic                      vga_hs_o,
    output logic                      vga_vs_o,
    output logic [11:0]               rgb_o,
    output logic                      frame_start_o
);

    localparam int CW_H   = H_MAX_W + 2;
    localparam int CW_V   = V_MAX_W + 2;
    localparam int XW     = $clog2(FB_W);
    localparam int YW     = $clog2(FB_H);
    localparam int DEPTH  = FB_W * FB_H;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NPAL   = 2 ** IDX_W;

    typedef enum logic [1:0] {
        CLS_BLANK  = 2'd0,
        CLS_BORDER = 2'd1,
        CLS_PIX    = 2'd2
    } pix_cls_t;

    // ---------------- stage 0: timing latch, counters, decode ----------------
    logic [H_MAX_W-1:0] hd_s, hf_s, hr_s, hb_s;
    logic [V_MAX_W-1:0] vd_s, vf_s, vr_s, vb_s;
    logic [H_MAX_W-1:0] hd_e, hf_e, hr_e, hb_e;
    logic [V_MAX_W-1:0] vd_e, vf_e, vr_e, vb_e;
    logic [CW_H-1:0]    h_cnt, ht, h_ss, h_se, fx;
    logic [CW_V-1:0]    v_cnt, vt, v_ss, v_se, fy;
    logic               at_org, h_wrap, v_wrap;
    logic               active, in_frame, rd_slot, hs_act, vs_act;
    logic [ADDR_W-1:0]  rd_addr, wr_addr;
    logic               wr_in_range, wr_ok;
    pix_cls_t           cls_d;

    // Counters only sit at (0,0) on the first cycle of a frame (or while
    // parked), so that cycle decodes straight from the inputs and the shadow
    // copy carries them for the rest of the frame.
    assign at_org = (h_cnt == '0) && (v_cnt == '0);
    assign hd_e = at_org ? hd_i : hd_s;
    assign hf_e = at_org ? hf_i : hf_s;
    assign hr_e = at_org ? hr_i : hr_s;
    assign hb_e = at_org ? hb_i : hb_s;
    assign vd_e = at_org ? vd_i : vd_s;
    assign vf_e = at_org ? vf_i : vf_s;
    assign vr_e = at_org ? vr_i : vr_s;
    assign vb_e = at_org ? vb_i : vb_s;

    assign h_ss = CW_H'(hd_e) + CW_H'(hf_e);
    assign h_se = h_ss + CW_H'(hr_e);
    assign ht   = h_se + CW_H'(hb_e);
    assign v_ss = CW_V'(vd_e) + CW_V'(vf_e);
    assign v_se = v_ss + CW_V'(vr_e);
    assign vt   = v_se + CW_V'(vb_e);

    // Compare h+1 against the total so a zero-length line (HT=0) still wraps.
    assign h_wrap = (h_cnt + CW_H'(1)) >= ht;
    assign v_wrap = (v_cnt + CW_V'(1)) >= vt;

    assign fx       = h_cnt >> SCALE_LOG2;
    assign fy       = v_cnt >> SCALE_LOG2;
    assign active   = (h_cnt < CW_H'(hd_e)) && (v_cnt < CW_V'(vd_e));
    assign in_frame = (fx < CW_H'(FB_W)) && (fy < CW_V'(FB_H));
    assign rd_slot  = en_i && active && in_frame;
    assign hs_act   = en_i && (h_cnt >= h_ss) && (h_cnt < h_se);
    assign vs_act   = en_i && (v_cnt >= v_ss) && (v_cnt < v_se);
    assign rd_addr  = ADDR_W'(32'(fy) * 32'(FB_W) + 32'(fx));

    always_comb begin
        cls_d = CLS_BLANK;
        if (en_i && active)
            cls_d = in_frame ? CLS_PIX : CLS_BORDER;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hd_s <= '0; hf_s <= '0; hr_s <= '0; hb_s <= '0;
            vd_s <= '0; vf_s <= '0; vr_s <= '0; vb_s <= '0;
        end else begin
            hd_s <= hd_e; hf_s <= hf_e; hr_s <= hr_e; hb_s <= hb_e;
            vd_s <= vd_e; vf_s <= vf_e; vr_s <= vr_e; vb_s <= vb_e;
            if (!en_i) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + CW_V'(1);
            end else begin
                h_cnt <= h_cnt + CW_H'(1);
            end
        end
    end

    // ---------------- write port ----------------
    // The port shares the single RAM port with scan-out and loses every
    // cycle the raster needs a stored pixel.
    assign wr_gnt_o    = wr_req_i && !rd_slot;
    assign wr_in_range = ({1'b0, wr_x_i} < (XW+1)'(FB_W)) &&
                         ({1'b0, wr_y_i} < (YW+1)'(FB_H));
    assign wr_ok       = wr_gnt_o && wr_in_range;
    assign wr_addr     = ADDR_W'(32'(wr_y_i) * 32'(FB_W) + 32'(wr_x_i));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) wr_err_o <= 1'b0;
        else        wr_err_o <= wr_gnt_o && !wr_in_range;
    end

    // ---------------- stage 1: framebuffer read ----------------
    logic [IDX_W-1:0] fb_mem [0:DEPTH-1];
    logic [IDX_W-1:0] fb_q;
    pix_cls_t         s1_cls;
    logic             s1_hs, s1_vs, s1_fs;

    always_ff @(posedge clk_i) begin
        if (wr_ok)   fb_mem[wr_addr] <= wr_idx_i;
        if (rd_slot) fb_q <= fb_mem[rd_addr];
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s1_cls <= CLS_BLANK;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_fs  <= 1'b0;
        end else begin
            s1_cls <= cls_d;
            s1_hs  <= hs_act;
            s1_vs  <= vs_act;
            s1_fs  <= en_i && at_org;
        end
    end

    // ---------------- stage 2: palette lookup ----------------
    // Lookup and write share an edge, so a same-cycle write to the entry
    // being looked up is seen from the following pixel on.
    logic [11:0] pal [0:NPAL-1];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < NPAL; i++)
                pal[i] <= (i == NPAL - 1) ? 12'hFFF : 12'h000;
        end else if (pal_we_i) begin
            pal[pal_addr_i] <= pal_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rgb_o         <= 12'h000;
            vga_hs_o      <= ~SYNC_POL;
            vga_vs_o      <= ~SYNC_POL;
            frame_start_o <= 1'b0;
        end else begin
            case (s1_cls)
                CLS_PIX:    rgb_o <= pal[fb_q];
                CLS_BORDER: rgb_o <= pal[0];
                default:    rgb_o <= 12'h000;
            endcase
            vga_hs_o      <= s1_hs ? SYNC_POL : ~SYNC_POL;
            vga_vs_o      <= s1_vs ? SYNC_POL : ~SYNC_POL;
            frame_start_o <= s1_fs;
        end
    end

endmodule

// File: tb/tb_vga_fb_core.sv
`timescale 1ns/1ps
module tb_vga_fb_core;

    logic        clk_i = 1'b0;
    logic        arst_i, en_i;
    logic [10:0] hd_i, hf_i, hr_i, hb_i;
    logic [10:0] vd_i, vf_i, vr_i, vb_i;
    logic        wr_req_i;
    logic [1:0]  wr_x_i;
    logic        wr_y_i;
    logic [1:0]  wr_idx_i;
    logic        wr_gnt_o, wr_err_o;
    logic        pal_we_i;
    logic [1:0]  pal_addr_i;
    logic [11:0] pal_data_i;
    logic        vga_hs_o, vga_vs_o;
    logic [11:0] rgb_o;
    logic        frame_start_o;

    always #5 clk_i = ~clk_i;

    vga_fb_core #(
        .H_MAX_W(11), .V_MAX_W(11), .FB_W(3), .FB_H(2),
        .IDX_W(2), .SCALE_LOG2(1), .SYNC_POL(1'b0)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i), .en_i(en_i),
        .hd_i(hd_i), .hf_i(hf_i), .hr_i(hr_i), .hb_i(hb_i),
        .vd_i(vd_i), .vf_i(vf_i), .vr_i(vr_i), .vb_i(vb_i),
        .wr_req_i(wr_req_i), .wr_x_i(wr_x_i), .wr_y_i(wr_y_i), .wr_idx_i(wr_idx_i),
        .wr_gnt_o(wr_gnt_o), .wr_err_o(wr_err_o),
        .pal_we_i(pal_we_i), .pal_addr_i(pal_addr_i), .pal_data_i(pal_data_i),
        .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o), .rgb_o(rgb_o),
        .frame_start_o(frame_start_o)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] cap_rgb [0:127];
    logic        cap_hs  [0:127];
    logic        cap_vs  [0:127];
    logic        cap_fs  [0:127];

    // 16-cycle line: hsync low at h=10..12; 8-line frame: vsync low lines 5,6
    logic [15:0] hs_line  = 16'b1110_0011_1111_1111;
    logic [7:0]  vs_frame = 8'b1001_1111;
    logic [11:0] pal_exp [0:3];
    int          row_idx [0:1][0:2];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_fs(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (frame_start_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Records the current sample then n-1 further cycles.
    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            cap_rgb[k] = rgb_o;
            cap_hs[k]  = vga_hs_o;
            cap_vs[k]  = vga_vs_o;
            cap_fs[k]  = frame_start_o;
        end
    endtask

    task automatic fb_write(input logic [1:0] x, input logic y, input logic [1:0] idx);
        wr_x_i = x; wr_y_i = y; wr_idx_i = idx; wr_req_i = 1'b1;
        tick();
        wr_req_i = 1'b0;
    endtask

    task automatic pal_write(input logic [1:0] a, input logic [11:0] d);
        pal_addr_i = a; pal_data_i = d; pal_we_i = 1'b1;
        tick();
        pal_we_i = 1'b0;
    endtask

    task automatic test_reset();
        arst_i = 1'b1; en_i = 1'b0;
        repeat (3) tick();
        n_vec++; if (rgb_o !== 12'h000) begin n_err++; $display("FAIL reset_rgb got=%h want=000", rgb_o); end
        n_vec++; if (vga_hs_o !== 1'b1) begin n_err++; $display("FAIL reset_hs got=%b want=1", vga_hs_o); end
        n_vec++; if (vga_vs_o !== 1'b1) begin n_err++; $display("FAIL reset_vs got=%b want=1", vga_vs_o); end
        n_vec++; if (frame_start_o !== 1'b0) begin n_err++; $display("FAIL reset_fs got=%b want=0", frame_start_o); end
        n_vec++; if (wr_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b want=0", wr_err_o); end
        arst_i = 1'b0;
        tick();
    endtask

    task automatic test_fb_load();
        wr_x_i = 2'd0; wr_y_i = 1'b0; wr_idx_i = 2'd3; wr_req_i = 1'b1;
        #1;
        n_vec++; if (wr_gnt_o !== 1'b1) begin n_err++; $display("FAIL gnt_disabled got=%b want=1", wr_gnt_o); end
        wr_req_i = 1'b0;
        tick();
        fb_write(2'd0, 1'b0, 2'd3);
        fb_write(2'd1, 1'b0, 2'd1);
        fb_write(2'd2, 1'b0, 2'd2);
        fb_write(2'd0, 1'b1, 2'd2);
        fb_write(2'd1, 1'b1, 2'd1);
        fb_write(2'd2, 1'b1, 2'd0);
        n_vec++; if (wr_err_o !== 1'b0) begin n_err++; $display("FAIL err_inrange got=%b want=0", wr_err_o); end
    endtask

    task automatic test_first_frame();
        en_i = 1'b1;
        tick();
        n_vec++; if (frame_start_o !== 1'b0) begin n_err++; $display("FAIL lat_fs_early got=%b want=0", frame_start_o); end
        tick();
        n_vec++; if (frame_start_o !== 1'b1) begin n_err++; $display("FAIL lat_fs got=%b want=1", frame_start_o); end
        n_vec++; if (rgb_o !== 12'hFFF) begin n_err++; $display("FAIL pal3_reset got=%h want=FFF", rgb_o); end
        tick();
        n_vec++; if (rgb_o !== 12'hFFF) begin n_err++; $display("FAIL pix_repeat got=%h want=FFF", rgb_o); end
        en_i = 1'b0;
        tick(); tick();
        n_vec++; if (rgb_o !== 12'h000) begin n_err++; $display("FAIL dis_rgb got=%h want=000", rgb_o); end
        n_vec++; if (vga_hs_o !== 1'b1 || vga_vs_o !== 1'b1) begin n_err++; $display("FAIL dis_sync got=%b%b want=11", vga_hs_o, vga_vs_o); end
    endtask

    task automatic test_wr_err();
        pal_write(2'd0, 12'h123);
        pal_write(2'd1, 12'hF00);
        pal_write(2'd2, 12'h0F0);
        pal_write(2'd3, 12'h00F);
        fb_write(2'd0, 1'b0, 2'd0);
        // x=3 would alias (0,1) if it were not discarded
        wr_x_i = 2'd3; wr_y_i = 1'b0; wr_idx_i = 2'd1; wr_req_i = 1'b1;
        #1;
        n_vec++; if (wr_gnt_o !== 1'b1) begin n_err++; $display("FAIL err_gnt got=%b want=1", wr_gnt_o); end
        tick();
        wr_req_i = 1'b0;
        n_vec++; if (wr_err_o !== 1'b1) begin n_err++; $display("FAIL err_pulse got=%b want=1", wr_err_o); end
        tick();
        n_vec++; if (wr_err_o !== 1'b0) begin n_err++; $display("FAIL err_clear got=%b want=0", wr_err_o); end
    endtask

    task automatic test_scaling_border();
        bit ok;
        int h, v;
        logic [11:0] exp_rgb;
        en_i = 1'b1;
        wait_fs(10, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL sc_fs_timeout got=0 want=1"); end
        capture(128);
        for (int k = 0; k < 128; k++) begin
            h = k % 16; v = k / 16;
            exp_rgb = 12'h000;
            if (v < 4 && h < 8)
                exp_rgb = (h < 6) ? pal_exp[row_idx[v/2][h/2]] : 12'h123;
            n_vec++; if (cap_rgb[k] !== exp_rgb) begin n_err++; $display("FAIL sc_rgb k=%0d got=%h want=%h", k, cap_rgb[k], exp_rgb); end
            n_vec++; if (cap_hs[k] !== hs_line[h]) begin n_err++; $display("FAIL sc_hs k=%0d got=%b want=%b", k, cap_hs[k], hs_line[h]); end
            n_vec++; if (cap_vs[k] !== vs_frame[v]) begin n_err++; $display("FAIL sc_vs k=%0d got=%b want=%b", k, cap_vs[k], vs_frame[v]); end
            n_vec++; if (cap_fs[k] !== (k == 0)) begin n_err++; $display("FAIL sc_fs k=%0d got=%b want=%b", k, cap_fs[k], (k == 0)); end
        end
        tick();
        n_vec++; if (frame_start_o !== 1'b1) begin n_err++; $display("FAIL sc_period got=%b want=1", frame_start_o); end
    endtask

    task automatic test_write_arb();
        bit ok;
        int h, v, k;
        logic exp_g;
        wr_x_i = 2'd1; wr_y_i = 1'b1; wr_idx_i = 2'd3; wr_req_i = 1'b1;
        tick();
        wait_fs(200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL arb_fs_timeout got=0 want=1"); end
        // rgb_o lags the counters by two cycles
        for (int j = 0; j < 128; j++) begin
            k = (j + 2) % 128; h = k % 16; v = k / 16;
            exp_g = !(h < 6 && v < 4);
            n_vec++; if (wr_gnt_o !== exp_g) begin n_err++; $display("FAIL arb_gnt k=%0d got=%b want=%b", k, wr_gnt_o, exp_g); end
            tick();
        end
        wr_req_i = 1'b0;
        n_vec++; if (wr_err_o !== 1'b0) begin n_err++; $display("FAIL arb_err got=%b want=0", wr_err_o); end
        wait_fs(200, ok);
        capture(128);
        n_vec++; if (cap_rgb[34] !== 12'h00F) begin n_err++; $display("FAIL arb_wr34 got=%h want=00F", cap_rgb[34]); end
        n_vec++; if (cap_rgb[51] !== 12'h00F) begin n_err++; $display("FAIL arb_wr51 got=%h want=00F", cap_rgb[51]); end
        n_vec++; if (cap_rgb[32] !== 12'h0F0) begin n_err++; $display("FAIL arb_alias got=%h want=0F0", cap_rgb[32]); end
        n_vec++; if (cap_rgb[36] !== 12'h123) begin n_err++; $display("FAIL arb_keep got=%h want=123", cap_rgb[36]); end
    endtask

    task automatic test_pal_hazard();
        tick();
        n_vec++; if (frame_start_o !== 1'b1) begin n_err++; $display("FAIL hz_fs got=%b want=1", frame_start_o); end
        tick();
        pal_addr_i = 2'd1; pal_data_i = 12'h0FF; pal_we_i = 1'b1;
        tick();
        pal_we_i = 1'b0;
        n_vec++; if (rgb_o !== 12'hF00) begin n_err++; $display("FAIL hz_old got=%h want=F00", rgb_o); end
        tick();
        n_vec++; if (rgb_o !== 12'h0FF) begin n_err++; $display("FAIL hz_new got=%h want=0FF", rgb_o); end
        repeat (15) tick();
        n_vec++; if (rgb_o !== 12'h0FF) begin n_err++; $display("FAIL hz_line1 got=%h want=0FF", rgb_o); end
    endtask

    task automatic test_timing_change();
        bit ok;
        wait_fs(200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL tc_fs_timeout got=0 want=1"); end
        hd_i = 11'd4;
        capture(128);
        n_vec++; if (cap_rgb[6] !== 12'h123) begin n_err++; $display("FAIL tc_old_border got=%h want=123", cap_rgb[6]); end
        n_vec++; if (cap_hs[10] !== 1'b0) begin n_err++; $display("FAIL tc_old_hs got=%b want=0", cap_hs[10]); end
        tick();
        n_vec++; if (frame_start_o !== 1'b1) begin n_err++; $display("FAIL tc_old_len got=%b want=1", frame_start_o); end
        // hd=4: 12-cycle lines, hsync at h=6..8, 96-cycle frame
        capture(96);
        n_vec++; if (cap_rgb[2] !== 12'h0FF) begin n_err++; $display("FAIL tc_pix got=%h want=0FF", cap_rgb[2]); end
        n_vec++; if (cap_rgb[4] !== 12'h000) begin n_err++; $display("FAIL tc_blank got=%h want=000", cap_rgb[4]); end
        n_vec++; if (cap_hs[6] !== 1'b0 || cap_hs[5] !== 1'b1 || cap_hs[9] !== 1'b1) begin
            n_err++; $display("FAIL tc_hs got=%b%b%b want=101", cap_hs[5], cap_hs[6], cap_hs[9]); end
        n_vec++; if (cap_rgb[12] !== 12'h123) begin n_err++; $display("FAIL tc_line1 got=%h want=123", cap_rgb[12]); end
        n_vec++; if (cap_vs[60] !== 1'b0 || cap_vs[59] !== 1'b1) begin n_err++; $display("FAIL tc_vs got=%b%b want=10", cap_vs[59], cap_vs[60]); end
        tick();
        n_vec++; if (frame_start_o !== 1'b1) begin n_err++; $display("FAIL tc_new_len got=%b want=1", frame_start_o); end
        hd_i = 11'd8;
    endtask

    task automatic test_reset_mid();
        repeat (7) tick();
        n_vec++; if (vga_hs_o !== 1'b0) begin n_err++; $display("FAIL rm_pre_hs got=%b want=0", vga_hs_o); end
        arst_i = 1'b1;
        #1;
        n_vec++; if (vga_hs_o !== 1'b1 || vga_vs_o !== 1'b1) begin n_err++; $display("FAIL rm_sync got=%b%b want=11", vga_hs_o, vga_vs_o); end
        n_vec++; if (rgb_o !== 12'h000) begin n_err++; $display("FAIL rm_rgb got=%h want=000", rgb_o); end
        repeat (2) tick();
        arst_i = 1'b0;
        tick();
        n_vec++; if (frame_start_o !== 1'b0 || rgb_o !== 12'h000) begin n_err++; $display("FAIL rm_flush fs=%b rgb=%h want 0/000", frame_start_o, rgb_o); end
        tick();
        n_vec++; if (frame_start_o !== 1'b1) begin n_err++; $display("FAIL rm_restart got=%b want=1", frame_start_o); end
        capture(128);
        n_vec++; if (cap_hs[10] !== 1'b0) begin n_err++; $display("FAIL rm_hs got=%b want=0", cap_hs[10]); end
        n_vec++; if (cap_rgb[34] !== 12'hFFF) begin n_err++; $display("FAIL rm_palreset got=%h want=FFF", cap_rgb[34]); end
        n_vec++; if (cap_rgb[2] !== 12'h000) begin n_err++; $display("FAIL rm_pal1 got=%h want=000", cap_rgb[2]); end
        tick();
        n_vec++; if (frame_start_o !== 1'b1) begin n_err++; $display("FAIL rm_len got=%b want=1", frame_start_o); end
    endtask

    task automatic test_zero_display();
        bit ok;
        hd_i = 11'd0;
        tick();
        wait_fs(300, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL zd_fs_timeout got=0 want=1"); end
        wr_x_i = 2'd3; wr_y_i = 1'b0; wr_idx_i = 2'd2; wr_req_i = 1'b1;
        #1;
        for (int j = 0; j < 64; j++) begin
            n_vec++; if (wr_gnt_o !== 1'b1 || rgb_o !== 12'h000) begin
                n_err++; $display("FAIL zd_blank j=%0d gnt=%b rgb=%h want 1/000", j, wr_gnt_o, rgb_o); end
            tick();
        end
        n_vec++; if (frame_start_o !== 1'b1) begin n_err++; $display("FAIL zd_len got=%b want=1", frame_start_o); end
        n_vec++; if (wr_err_o !== 1'b1) begin n_err++; $display("FAIL zd_err got=%b want=1", wr_err_o); end
        wr_req_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pal_exp = '{12'h123, 12'hF00, 12'h0F0, 12'h00F};
        row_idx = '{'{0, 1, 2}, '{2, 1, 0}};
        arst_i = 1'b1; en_i = 1'b0;
        hd_i = 11'd8; hf_i = 11'd2; hr_i = 11'd3; hb_i = 11'd3;
        vd_i = 11'd4; vf_i = 11'd1; vr_i = 11'd2; vb_i = 11'd1;
        wr_req_i = 1'b0; wr_x_i = '0; wr_y_i = '0; wr_idx_i = '0;
        pal_we_i = 1'b0; pal_addr_i = '0; pal_data_i = '0;
        test_reset();
        test_fb_load();
        test_first_frame();
        test_wr_err();
        test_scaling_border();
        test_write_arb();
        test_pal_hazard();
        test_timing_change();
        test_reset_mid();
        test_zero_display();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
